// File: rtl/activation_grad_unit_pkg.sv
// pe_act_pkg: activation type codes, band thresholds and lane classes shared by forward and backward activation paths
// Exports: ACT_* type codes, GELU_TH/SWISH_TH band half-widths, lane_cls_e, grad_state_e
package pe_act_pkg;
  localparam logic [7:0] ACT_GELU    = 8'd0;
  localparam logic [7:0] ACT_RELU    = 8'd1;
  localparam logic [7:0] ACT_SWISH   = 8'd2;
  localparam logic [7:0] ACT_SIGMOID = 8'd3;
  localparam logic [7:0] ACT_TANH    = 8'd4;
  localparam int GELU_TH  = 'h4000;
  localparam int SWISH_TH = 'h2000;
  typedef enum logic [1:0] {CLS_ZERO, CLS_HALF, CLS_QUARTER, CLS_PASS} lane_cls_e;
  typedef enum logic {IDLE, PKT} grad_state_e;
endpackage

// File: rtl/activation_grad_unit_if.sv
// activation_grad_unit_if: vector stream in (x, dy, type, last) and gradient stream out (dx, last)
// master = stream source/sink side, slave = the gradient unit
interface activation_grad_unit_if #(parameter int DATA_WIDTH = 32, parameter int VECTOR_WIDTH = 32);
  logic                               in_valid;
  logic                               in_ready;
  logic                               in_last;
  logic [7:0]                         activation_type;
  logic [DATA_WIDTH*VECTOR_WIDTH-1:0] x_i;
  logic [DATA_WIDTH*VECTOR_WIDTH-1:0] dy_i;
  logic                               out_valid;
  logic                               out_ready;
  logic                               out_last;
  logic [DATA_WIDTH*VECTOR_WIDTH-1:0] dx_o;
  modport master(output in_valid, in_last, activation_type, x_i, dy_i, out_ready,
                 input in_ready, out_valid, out_last, dx_o);
  modport slave(input in_valid, in_last, activation_type, x_i, dy_i, out_ready,
                output in_ready, out_valid, out_last, dx_o);
endinterface

// File: rtl/activation_grad_unit_lane.sv
// activation_grad_lane: combinational derivative class of one lane's pre-activation x
// Ports: x (signed lane value), act_type (type code), cls (zero/half/quarter/pass)
module activation_grad_lane
  import pe_act_pkg::*;
#(parameter int DATA_WIDTH = 32)
(
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic [7:0]                   act_type,
  output lane_cls_e                    cls
);
  localparam logic signed [DATA_WIDTH-1:0] TH_G = DATA_WIDTH'(GELU_TH);
  localparam logic signed [DATA_WIDTH-1:0] TH_S = DATA_WIDTH'(SWISH_TH);
  logic signed [DATA_WIDTH-1:0] th;
  logic pos, above, below;
  assign th    = act_type == ACT_SWISH ? TH_S : TH_G;
  assign pos   = !x[DATA_WIDTH-1] && |x;
  // band edges are inclusive on both sides: only strictly outside counts as above/below
  assign above = x > th;
  assign below = x < -th;
  always_comb
    cls = act_type == ACT_RELU ? (pos ? CLS_PASS : CLS_ZERO) :
          (act_type == ACT_GELU || act_type == ACT_SWISH) ? (above ? CLS_PASS : below ? CLS_ZERO : CLS_HALF) :
          act_type == ACT_SIGMOID ? (above || below ? CLS_ZERO : CLS_QUARTER) :
          act_type == ACT_TANH ? (above || below ? CLS_ZERO : CLS_PASS) : CLS_PASS;
endmodule

// File: rtl/activation_grad_unit.sv
// activation_grad_unit: dx = dy * f'(x) per lane, 2-stage stallable pipeline with packet FSM and stats
// Ports: clk, rst (async high), clear_stats, bus (slave stream), pkt_count, zero_count (saturating), in_packet
module activation_grad_unit
  import pe_act_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int VECTOR_WIDTH = 32,
  parameter int CNT_WIDTH    = 32
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_stats,
  activation_grad_unit_if.slave bus,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] zero_count,
  output logic                 in_packet
);
  localparam int ZW = $clog2(VECTOR_WIDTH + 1);
  localparam int DW = DATA_WIDTH;
  grad_state_e state;
  logic [7:0] pkt_type, cur_type;
  lane_cls_e cls [VECTOR_WIDTH];
  lane_cls_e s1_cls [VECTOR_WIDTH];
  logic [DW*VECTOR_WIDTH-1:0] s1_dy, dx_next;
  logic s1_valid, s1_last, s2_valid, s1_adv, s2_adv, accept, out_hs;
  logic [ZW-1:0] s2_zc, zc_next;
  logic [CNT_WIDTH:0] zc_sum;
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;
  assign accept       = bus.in_valid && s1_adv;
  assign out_hs       = s2_valid && bus.out_ready;
  assign bus.out_valid = s2_valid;
  assign in_packet    = state == PKT;
  // the first beat of a packet classifies with the live type, later beats with the latched one
  assign cur_type     = state == IDLE ? bus.activation_type : pkt_type;
  assign zc_sum       = {1'b0, zero_count} + (CNT_WIDTH+1)'(s2_zc);
  for (genvar i = 0; i < VECTOR_WIDTH; i++) begin : g_lane
    activation_grad_lane #(.DATA_WIDTH(DW)) u_lane (
      .x(bus.x_i[i*DW +: DW]),
      .act_type(cur_type),
      .cls(cls[i])
    );
  end
  // sign-fill concatenations keep the shifts arithmetic regardless of expression context
  always_comb begin
    dx_next = '0;
    zc_next = '0;
    for (int k = 0; k < VECTOR_WIDTH; k++) begin
      dx_next[k*DW +: DW] = s1_cls[k] == CLS_ZERO ? '0 :
                            s1_cls[k] == CLS_HALF ? {s1_dy[k*DW+DW-1], s1_dy[k*DW+1 +: DW-1]} :
                            s1_cls[k] == CLS_QUARTER ? {{2{s1_dy[k*DW+DW-1]}}, s1_dy[k*DW+2 +: DW-2]} :
                            s1_dy[k*DW +: DW];
      zc_next = zc_next + ZW'(s1_cls[k] == CLS_ZERO);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      pkt_type     <= '0;
      s1_valid     <= 1'b0;
      s1_last      <= 1'b0;
      s1_dy        <= '0;
      for (int k = 0; k < VECTOR_WIDTH; k++) s1_cls[k] <= CLS_ZERO;
      s2_valid     <= 1'b0;
      s2_zc        <= '0;
      bus.out_last <= 1'b0;
      bus.dx_o     <= '0;
      pkt_count    <= '0;
      zero_count   <= '0;
    end else begin
      if (accept) begin
        if (state == IDLE) pkt_type <= bus.activation_type;
        state <= bus.in_last ? IDLE : PKT;
      end
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_dy   <= bus.dy_i;
          s1_last <= bus.in_last;
          for (int k = 0; k < VECTOR_WIDTH; k++) s1_cls[k] <= cls[k];
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          bus.dx_o     <= dx_next;
          bus.out_last <= s1_last;
          s2_zc        <= zc_next;
        end
      end
      if (clear_stats) begin
        pkt_count  <= '0;
        zero_count <= '0;
      end else if (out_hs) begin
        if (bus.out_last) pkt_count <= pkt_count + 1'b1;
        zero_count <= zc_sum[CNT_WIDTH] ? '1 : zc_sum[CNT_WIDTH-1:0];
      end
    end
endmodule

// File: tb/tb_activation_grad_unit.sv
// tb_activation_grad_unit: directed table, corner sequences and random stream against a reference model
module tb_activation_grad_unit;
  import pe_act_pkg::*;
  localparam int DW = 32;
  localparam int VW = 32;
  localparam int CW = 8;
  localparam int BW = DW * VW;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {int act; int x; int dy; int dx;} vec_t;
  typedef struct {logic [BW-1:0] dx; bit last; int zc;} exp_t;

  logic clk = 0;
  logic rst = 1;
  logic clear_stats = 0;
  logic [CW-1:0] pkt_count, zero_count;
  logic in_packet;
  int n_cmp = 0;
  int n_fail = 0;
  bit rnd_ready = 0;

  exp_t q[$];
  bit m_inpkt;
  int m_type, m_pkt, m_zc;
  bit held, held_last;
  logic [BW-1:0] held_dx;

  int th_list[11] = '{'h4000, 'h4001, -'h4000, -'h4001, 'h2000, 'h2001, -'h2000, -'h2001, 0, 1, -1};
  vec_t tbl[$] = '{
    '{1, 5, 'h100, 'h100},         '{1, -5, 'h100, 0},           '{1, 0, 'h100, 0},
    '{1, -5, 0, 0},                '{0, 'h4001, -'h100, -'h100}, '{0, 'h4000, -'h100, -'h80},
    '{0, -'h4001, -'h100, 0},      '{0, -'h4000, -3, -2},        '{0, 0, 7, 3},
    '{2, 'h2001, 'h11, 'h11},      '{2, 'h2000, 'h11, 8},        '{2, -'h2001, 'h11, 0},
    '{2, -'h2000, -1, -1},         '{3, 0, 'h103, 'h40},         '{3, 'h4000, -5, -2},
    '{3, 'h4001, 'h100, 0},        '{3, -'h4001, 'h100, 0},      '{4, 'h4000, 'h123, 'h123},
    '{4, -'h4000, -7, -7},         '{4, 'h4001, 'h123, 0},       '{7, -5, 'h55, 'h55},
    '{255, 'h7fffffff, 0, 0}
  };

  activation_grad_unit_if #(.DATA_WIDTH(DW), .VECTOR_WIDTH(VW)) bus();

  activation_grad_unit #(.DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .clear_stats(clear_stats),
    .bus(bus),
    .pkt_count(pkt_count),
    .zero_count(zero_count),
    .in_packet(in_packet)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cmp_dx(input string name, input logic [BW-1:0] a, input logic [BW-1:0] e);
    int bad = 0;
    for (int k = VW - 1; k >= 0; k--) if (a[k*DW +: DW] !== e[k*DW +: DW]) bad = k;
    chk($sformatf("%s lane%0d", name, bad), $signed(a[bad*DW +: DW]), $signed(e[bad*DW +: DW]));
  endtask

  function automatic int ref_lane(input int t, input int x, input int dy, output bit z);
    int th = (t == 2) ? 'h2000 : 'h4000;
    z = 0;
    case (t)
      1: begin
        if (x > 0) return dy;
        z = 1;
        return 0;
      end
      0, 2: begin
        if (x > th) return dy;
        if (x < -th) begin
          z = 1;
          return 0;
        end
        return dy >>> 1;
      end
      3: begin
        if (x >= -th && x <= th) return dy >>> 2;
        z = 1;
        return 0;
      end
      4: begin
        if (x >= -th && x <= th) return dy;
        z = 1;
        return 0;
      end
      default: return dy;
    endcase
  endfunction

  function automatic logic [BW-1:0] fill(input int v);
    logic [BW-1:0] r;
    for (int k = 0; k < VW; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic int rand_x();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return th_list[$urandom_range(0, 10)];
      default: return int'($urandom_range(0, 'hC000)) - 'h6000;
    endcase
  endfunction

  function automatic logic [BW-1:0] rand_xv();
    logic [BW-1:0] r;
    for (int k = 0; k < VW; k++) r[k*DW +: DW] = rand_x();
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_dv();
    logic [BW-1:0] r;
    for (int k = 0; k < VW; k++) r[k*DW +: DW] = $urandom;
    return r;
  endfunction

  // scoreboard and counter model, evaluated mid-cycle when all signals are settled
  always @(negedge clk) begin
    exp_t e;
    int t;
    bit z;
    if (rst) begin
      q.delete();
      m_inpkt = 0;
      m_pkt = 0;
      m_zc = 0;
      held = 0;
    end else begin
      chk("in_packet", in_packet, m_inpkt);
      if (held && bus.out_valid) begin
        chk("hold dx stable", bus.dx_o == held_dx, 1);
        chk("hold last stable", bus.out_last, held_last);
      end
      if (bus.in_valid && bus.in_ready) begin
        t = m_inpkt ? m_type : int'(bus.activation_type);
        m_type = t;
        m_inpkt = !bus.in_last;
        e.dx = '0;
        e.zc = 0;
        e.last = bus.in_last;
        for (int k = 0; k < VW; k++) begin
          e.dx[k*DW +: DW] = ref_lane(t, int'(bus.x_i[k*DW +: DW]), int'(bus.dy_i[k*DW +: DW]), z);
          e.zc += int'(z);
        end
        q.push_back(e);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("pkt_count", pkt_count, m_pkt);
        chk("zero_count", zero_count, m_zc);
        if (q.size() == 0) chk("unexpected beat", 1, 0);
        else begin
          e = q.pop_front();
          cmp_dx("dx", bus.dx_o, e.dx);
          chk("out_last", bus.out_last, e.last);
          m_pkt = (m_pkt + int'(e.last)) % (CMAX + 1);
          m_zc = (m_zc + e.zc > CMAX) ? CMAX : m_zc + e.zc;
        end
      end
      if (clear_stats) begin
        m_pkt = 0;
        m_zc = 0;
      end
      held = bus.out_valid && !bus.out_ready;
      held_dx = bus.dx_o;
      held_last = bus.out_last;
    end
  end

  always @(posedge clk)
    if (rnd_ready) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // call at posedge+1; returns at posedge+1 right after the beat was accepted
  task automatic send(input int t, input logic [BW-1:0] x, input logic [BW-1:0] d, input bit last);
    bit ok;
    bus.in_valid = 1;
    bus.activation_type = 8'(t);
    bus.x_i = x;
    bus.dy_i = d;
    bus.in_last = last;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
      if (ok) return;
    end
    chk("accept timeout", 0, 1);
  endtask

  task automatic drain();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.out_valid) return;
    end
    chk("drain timeout", q.size(), 0);
  endtask

  initial begin
    logic [BW-1:0] xv;
    int n_acc;
    int len, t;
    bus.in_valid = 0;
    bus.in_last = 0;
    bus.activation_type = 0;
    bus.x_i = '0;
    bus.dy_i = '0;
    bus.out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", bus.in_ready, 1);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_last", bus.out_last, 0);
    chk("rst dx_o zero", bus.dx_o == '0, 1);
    chk("rst pkt_count", pkt_count, 0);
    chk("rst zero_count", zero_count, 0);
    chk("rst in_packet", in_packet, 0);
    tick();
    rst = 0;

    // ReLU single-beat packet with mixed lanes
    clear_stats = 1;
    tick();
    clear_stats = 0;
    xv = fill(5);
    xv[DW +: DW] = -5;
    xv[2*DW +: DW] = 0;
    send(ACT_RELU, xv, fill('h100), 1);
    bus.in_valid = 0;
    @(negedge clk);
    chk("relu latency s1", bus.out_valid, 0);
    @(negedge clk);
    chk("relu latency s2", bus.out_valid, 1);
    chk("relu lane0", $signed(bus.dx_o[0 +: DW]), 'h100);
    chk("relu lane1", $signed(bus.dx_o[DW +: DW]), 0);
    chk("relu lane2", $signed(bus.dx_o[2*DW +: DW]), 0);
    tick();
    @(negedge clk);
    chk("relu zero_count", zero_count, 2);
    chk("relu pkt_count", pkt_count, 1);
    tick();

    // directed per-type rule table, broadcast to every lane
    foreach (tbl[i]) begin
      send(tbl[i].act, fill(tbl[i].x), fill(tbl[i].dy), 1);
      bus.in_valid = 0;
      @(negedge clk);
      chk($sformatf("tbl%0d latency s1", i), bus.out_valid, 0);
      @(negedge clk);
      chk($sformatf("tbl%0d latency s2", i), bus.out_valid, 1);
      chk($sformatf("tbl%0d dx lane0", i), $signed(bus.dx_o[0 +: DW]), tbl[i].dx);
      chk($sformatf("tbl%0d dx lane31", i), $signed(bus.dx_o[31*DW +: DW]), tbl[i].dx);
      tick();
    end

    // 3-beat packet: type changes to Tanh mid-packet are ignored
    send(ACT_RELU, fill(-5), fill(3), 0);
    bus.in_valid = 0;
    @(negedge clk);
    chk("fsm in_packet beat1", in_packet, 1);
    tick();
    send(ACT_TANH, fill('h4001), fill(7), 0);
    bus.in_valid = 0;
    @(negedge clk);
    chk("fsm in_packet beat2", in_packet, 1);
    chk("fsm beat1 relu dx", $signed(bus.dx_o[0 +: DW]), 0);
    tick();
    send(ACT_TANH, fill(-3), fill(9), 1);
    bus.in_valid = 0;
    @(negedge clk);
    chk("fsm in_packet beat3", in_packet, 0);
    chk("fsm beat2 relu dx", $signed(bus.dx_o[0 +: DW]), 7);
    drain();
    tick();

    // stall for 5 cycles in the middle of a continuous stream
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) send(ACT_RELU, rand_xv(), rand_dv(), i == 11);
        bus.in_valid = 0;
      end
      begin
        repeat (4) tick();
        bus.out_ready = 0;
        repeat (5) begin
          @(negedge clk);
          if (bus.in_valid && bus.in_ready) n_acc++;
          tick();
        end
        @(negedge clk);
        chk("stall in_ready low", bus.in_ready, 0);
        chk("stall accepts bounded", n_acc <= 2, 1);
        tick();
        bus.out_ready = 1;
      end
    join
    drain();
    tick();

    // zero_count saturation: 9 beats x 32 forced zeros exceeds 8-bit range
    clear_stats = 1;
    tick();
    clear_stats = 0;
    for (int i = 0; i < 9; i++) send(ACT_RELU, fill(-1), rand_dv(), i == 8);
    bus.in_valid = 0;
    drain();
    chk("sat zero_count", zero_count, CMAX);
    chk("sat pkt_count", pkt_count, 1);
    tick();

    // clear_stats in the same cycle as a counted output beat
    bus.out_ready = 0;
    send(ACT_RELU, fill(-1), fill(1), 1);
    bus.in_valid = 0;
    repeat (2) tick();
    clear_stats = 1;
    bus.out_ready = 1;
    tick();
    clear_stats = 0;
    @(negedge clk);
    chk("clear prio zero_count", zero_count, 0);
    chk("clear prio pkt_count", pkt_count, 0);
    tick();

    // reset with two beats in flight mid-packet
    send(ACT_GELU, rand_xv(), rand_dv(), 0);
    send(ACT_GELU, rand_xv(), rand_dv(), 0);
    bus.in_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst in_packet", in_packet, 0);
    chk("midrst pkt_count", pkt_count, 0);
    chk("midrst zero_count", zero_count, 0);
    chk("midrst in_ready", bus.in_ready, 1);
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("postrst out_valid c%0d", i), bus.out_valid, 0);
    end
    tick();

    // random packets with random backpressure against the model
    rnd_ready = 1;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 4);
      t = $urandom_range(0, 5);
      if (t == 5) t = $urandom_range(5, 255);
      for (int b = 0; b < len; b++) begin
        send(b == 0 ? t : int'($urandom_range(0, 255)), rand_xv(), rand_dv(), b == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          bus.in_valid = 0;
          tick();
        end
      end
    end
    bus.in_valid = 0;
    drain();
    rnd_ready = 0;
    tick();
    bus.out_ready = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
